// File: rtl/slot_pkg.sv
// Shared types and elaboration-time helpers for the slot machine core.
// Reel step sizes and the spin length are derived here.
package slot_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SPIN,
        EVAL
    } state_t;

    function automatic int unsigned reel_step(input int unsigned i, input int unsigned reel_bits);
        return (2 * i + 1) % (1 << reel_bits);
    endfunction

    function automatic int unsigned spin_len(input int unsigned spin_cycles,
                                             input int unsigned num_reels,
                                             input int unsigned stagger);
        return spin_cycles + (num_reels - 1) * stagger;
    endfunction

endpackage

// File: rtl/slot_machine_core_if.sv
// Board-side controls and display-side status of the slot machine core.
interface slot_machine_core_if #(
    parameter int unsigned NUM_REELS   = 3,
    parameter int unsigned REEL_BITS   = 2,
    parameter int unsigned CREDIT_BITS = 5
);
    logic                            load_en;
    logic [CREDIT_BITS-1:0]          load_value;
    logic                            withdraw;
    logic                            start;
    logic [NUM_REELS*REEL_BITS-1:0]  reels;
    logic [CREDIT_BITS-1:0]          credits;
    logic                            busy;
    logic                            win_valid;
    logic                            win;
    logic                            no_credit;
    logic                            saturated;

    modport master (
        output load_en, load_value, withdraw, start,
        input  reels, credits, busy, win_valid, win, no_credit, saturated
    );

    modport slave (
        input  load_en, load_value, withdraw, start,
        output reels, credits, busy, win_valid, win, no_credit, saturated
    );
endinterface

// File: rtl/slot_reel.sv
// One reel: wrap-around symbol counter advancing by STEP when enabled.
module slot_reel #(
    parameter int unsigned REEL_BITS = 2,
    parameter int unsigned STEP      = 1
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 advance,
    output logic [REEL_BITS-1:0] value
);
    localparam logic [REEL_BITS-1:0] STEP_W = REEL_BITS'(STEP);

    logic [REEL_BITS-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (advance) begin
            value_d = value_q + STEP_W;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
endmodule

// File: rtl/slot_machine_core.sv
// Slot machine datapath: N staggered reels, saturating credit register
// and IDLE/SPIN/EVAL control with registered status outputs.
module slot_machine_core
    import slot_pkg::*;
#(
    parameter int unsigned NUM_REELS   = 3,
    parameter int unsigned REEL_BITS   = 2,
    parameter int unsigned CREDIT_BITS = 5,
    parameter int unsigned SPIN_CYCLES = 4,
    parameter int unsigned STAGGER     = 2,
    parameter int unsigned PAY_ALL     = 2,
    parameter int unsigned PAY_PAIR    = 0
) (
    input  logic               clk,
    input  logic               clear,
    slot_machine_core_if.slave bus
);
    localparam int unsigned T  = spin_len(SPIN_CYCLES, NUM_REELS, STAGGER);
    localparam int unsigned TW = $clog2(T + 1);
    localparam logic [TW-1:0] T_LAST = TW'(T - 1);
    localparam logic [CREDIT_BITS:0] PAY_ALL_W  = (CREDIT_BITS + 1)'(PAY_ALL);
    localparam logic [CREDIT_BITS:0] PAY_PAIR_W = (CREDIT_BITS + 1)'(PAY_PAIR);
    localparam logic [CREDIT_BITS:0] CREDIT_MAX = {1'b0, {CREDIT_BITS{1'b1}}};

    state_t                   state_q, state_d;
    logic                     start_q;
    logic [TW-1:0]            t_q, t_d;
    logic [CREDIT_BITS-1:0]   credits_q, credits_d;
    logic                     busy_q, busy_d;
    logic                     win_valid_q, win_valid_d;
    logic                     win_q, win_d;
    logic                     no_credit_q, no_credit_d;
    logic                     saturated_q, saturated_d;

    logic [NUM_REELS-1:0]           advance;
    logic [REEL_BITS-1:0]           reel_val [NUM_REELS];
    logic [NUM_REELS*REEL_BITS-1:0] reels_w;
    logic                           all_eq, any_adj, pair;
    logic                           start_edge;
    logic [CREDIT_BITS:0]           pay, sum;

    // Reel i keeps spinning for i*STAGGER clocks after reel 0 has stopped.
    for (genvar i = 0; i < NUM_REELS; i++) begin : g_reel
        localparam logic [TW-1:0] LIMIT = TW'(SPIN_CYCLES + i * STAGGER);

        assign advance[i] = (state_q == SPIN) && (t_q < LIMIT);

        slot_reel #(
            .REEL_BITS (REEL_BITS),
            .STEP      (reel_step(i, REEL_BITS))
        ) u_reel (
            .clk     (clk),
            .clear   (clear),
            .advance (advance[i]),
            .value   (reel_val[i])
        );

        assign reels_w[i*REEL_BITS +: REEL_BITS] = reel_val[i];
    end

    always_comb begin
        all_eq  = 1'b1;
        any_adj = 1'b0;
        for (int unsigned i = 1; i < NUM_REELS; i++) begin
            if (reel_val[i] != reel_val[0]) all_eq = 1'b0;
            if (reel_val[i] == reel_val[i-1]) any_adj = 1'b1;
        end
        pair = (PAY_PAIR != 0) && any_adj && !all_eq;
    end

    assign start_edge = bus.start & ~start_q;
    assign pay = all_eq ? PAY_ALL_W : (pair ? PAY_PAIR_W : '0);
    assign sum = {1'b0, credits_q} + pay;

    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        credits_d   = credits_q;
        win_d       = win_q;
        saturated_d = saturated_q;
        win_valid_d = 1'b0;
        no_credit_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.withdraw) begin
                    credits_d   = '0;
                    saturated_d = 1'b0;
                end else if (bus.load_en) begin
                    credits_d   = bus.load_value;
                    saturated_d = 1'b0;
                end else if (start_edge) begin
                    if (credits_q != '0) begin
                        credits_d = credits_q - 1'b1;
                        t_d       = '0;
                        win_d     = 1'b0;
                        state_d   = SPIN;
                    end else begin
                        no_credit_d = 1'b1;
                    end
                end
            end
            SPIN: begin
                t_d = t_q + 1'b1;
                if (t_q == T_LAST) begin
                    t_d     = '0;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (sum > CREDIT_MAX) begin
                    credits_d   = '1;
                    saturated_d = 1'b1;
                end else begin
                    credits_d = sum[CREDIT_BITS-1:0];
                end
                win_d       = all_eq;
                win_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            t_q         <= '0;
            credits_q   <= '0;
            busy_q      <= 1'b0;
            win_valid_q <= 1'b0;
            win_q       <= 1'b0;
            no_credit_q <= 1'b0;
            saturated_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= bus.start;
            t_q         <= t_d;
            credits_q   <= credits_d;
            busy_q      <= busy_d;
            win_valid_q <= win_valid_d;
            win_q       <= win_d;
            no_credit_q <= no_credit_d;
            saturated_q <= saturated_d;
        end
    end

    assign bus.reels     = reels_w;
    assign bus.credits   = credits_q;
    assign bus.busy      = busy_q;
    assign bus.win_valid = win_valid_q;
    assign bus.win       = win_q;
    assign bus.no_credit = no_credit_q;
    assign bus.saturated = saturated_q;
endmodule

// File: doc/slot_machine_core.md
Name: slot_machine_core

Overview:
- Parametrised successor of the three-reel slot game datapath.
- Holds N reel counters, a credit register and a spin state machine in one clocked block.
- Spins reels with staggered stop times, evaluates win/pair, and pays out with saturation.
- Sits between board I/O (switches/keys, already synchronised, active-high) and LED/HEX display logic.

Parameters:
NUM_REELS, 3, number of reels (>=2)
REEL_BITS, 2, bits per reel symbol; symbols 0..2^REEL_BITS-1
CREDIT_BITS, 5, credit register width
SPIN_CYCLES, 4, clocks reel 0 advances per spin (>=1)
STAGGER, 2, extra clocks each subsequent reel advances (>=0)
PAY_ALL, 2, credits added when all reels equal
PAY_PAIR, 0, credits added when any two adjacent reels equal but not all (0 disables)

Ports:
clk  in  1  system clock, all state on rising edge
clear  in  1  asynchronous active-high reset
load_en  in  1  level; in IDLE sets credits to load_value
load_value  in  CREDIT_BITS  credit amount to load
withdraw  in  1  level; in IDLE clears credits to 0
start  in  1  active-high level; rising edge requests a spin
reels  out  NUM_REELS*REEL_BITS  reel i at bits [i*REEL_BITS +: REEL_BITS]
credits  out  CREDIT_BITS  current credit count
busy  out  1  high in SPIN and EVAL
win_valid  out  1  one-cycle pulse when a spin result is final
win  out  1  all reels equal; valid with win_valid, held until next spin
no_credit  out  1  one-cycle pulse: start edge in IDLE with credits==0
saturated  out  1  sticky: payout clipped at max; cleared by withdraw/load/clear

Behaviour:
- Reset (async, clear=1): state IDLE, reels=0, credits=0, start_q=0, t=0, all flags 0.
- Start edge: start & ~start_q; start_q registered every cycle in all states. Holding start high does not retrigger.
- IDLE priority, evaluated per cycle:
  - withdraw: credits<=0, saturated<=0.
  - else load_en: credits<=load_value, saturated<=0.
  - else start edge with credits>0: credits<=credits-1, t<=0, go SPIN.
  - else start edge with credits==0: no_credit pulse, stay IDLE.
- SPIN:
  - T = SPIN_CYCLES + (NUM_REELS-1)*STAGGER; t counts 0..T-1, width clog2(T+1).
  - Each cycle, reel i advances by step_i = (2i+1) mod 2^REEL_BITS (wrap-around) while t < SPIN_CYCLES + i*STAGGER.
  - At t==T-1, go EVAL. SPIN lasts exactly T cycles.
  - load_en, withdraw and start edges are ignored.
- EVAL (1 cycle):
  - all_eq: every reel equal. pair: PAY_PAIR>0, any adjacent pair equal, not all_eq.
  - pay = all_eq ? PAY_ALL : pair ? PAY_PAIR : 0.
  - credits <= min(credits+pay, 2^CREDIT_BITS-1); set saturated if clipped. Width-extend by 1 bit for the sum.
  - win<=all_eq; win_valid pulses the same edge as the return to IDLE.
- Latency: start edge sampled at edge k, then busy from k+1. win_valid and updated credits are visible after edge k+T+1.
- Reels hold their values in IDLE; next spin continues from them (deterministic sequence).
- clear mid-SPIN/EVAL: immediate return to reset values, no payout, spent credit not refunded.

Decomposition:
- Package slot_pkg: state enum {IDLE, SPIN, EVAL}, function reel_step(i, REEL_BITS), function spin_len(T).
- One sub-module, slot_reel: REEL_BITS counter with async clear, advance enable and STEP parameter; instantiated NUM_REELS times by generate.
- Credit/FSM logic stays in slot_machine_core.

Test Plan:
(defaults: T=8, steps 1,3,1)
- Reset: assert clear mid-operation -> reels=0, credits=0, busy=0, all pulses 0 within same cycle (async).
- Load and first spin:
  - load_value=3, load_en 1 cycle -> credits=3.
  - start rise -> credits=2, busy 8+1 cycles, reels=(0,2,0).
  - win_valid pulse with win=0, credits=2.
- Second spin: start rise -> credits=1, reels=(0,0,0), win=1 with win_valid, credits=3.
- Credit boundary: credits=0, start rise -> no_credit pulse 1 cycle, state stays IDLE, reels unchanged. Hold start high 20 cycles after load_value=1 -> exactly one spin.
- Saturation: CREDIT_BITS=5, PAY_ALL=2, credits loaded 31, spin landing on win -> credits=30 then 31 with saturated=1 (30+2 clipped). Withdraw -> credits=0, saturated=0.
- Ignored inputs: during SPIN pulse load_en (value 7), withdraw, start -> credits unaffected, single spin completes. PAY_PAIR=1 run landing on (0,2,2) -> credits +1, win=0.
